tickgen_nco: RTL and testbench
==============================

TICKGEN_NCO -- requirements
Module: tickgen_nco

Interface
REQ-001 SHALL have parameter Channels, default 4, number of independent clock/tick outputs (1..16).
REQ-002 SHALL have parameter Width, default 32, phase-accumulator and increment width in bits (8..48).
REQ-003 SHALL have port clock  input  1  single system clock; all logic in this domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ckena  input  Channels  per-channel run enable.
REQ-006 SHALL have port cfg_wr  input  1  single-cycle write strobe for channel configuration.
REQ-007 SHALL have port cfg_ch  input  4  target channel index of write.
REQ-008 SHALL have port cfg_incr  input  Width  phase increment; output frequency = f_clock * cfg_incr / 2^Width.
REQ-009 SHALL have port cfg_mode  input  1  0 = square output, 1 = pulse output.
REQ-010 SHALL have port sync_mask  input  Channels  per-channel phase clear, sampled every cycle.
REQ-011 SHALL have port ckout  output  Channels  per-channel clock output (square or pulse per mode).
REQ-012 SHALL have port tick  output  Channels  per-channel one-cycle wrap strobe.

Function
REQ-013 Each channel SHALL hold registers acc[Width], incr[Width], mode, pend_incr[Width], pend_mode, pend_valid.
REQ-014 On each clock edge with ckena[ch]=1 and sync_mask[ch]=0, acc SHALL become (acc + incr) mod 2^Width; carry-out registered into tick[ch] on the same edge.
REQ-015 tick[ch] SHALL be high for exactly the one cycle following the edge whose add carried out; otherwise 0.
REQ-016 Square mode: ckout[ch] SHALL be acc[Width-1] taken directly from the register (no combinational glitch path).
REQ-017 Pulse mode: ckout[ch] SHALL equal tick[ch].
REQ-018 ckena[ch]=0: acc SHALL hold, tick[ch]=0, ckout holds (square) or 0 (pulse).
REQ-019 incr=0 SHALL freeze acc and produce no ticks.
REQ-020 cfg_wr with cfg_ch >= Channels SHALL be ignored.
REQ-021 cfg_wr to a channel with ckena=0 or incr=0 SHALL load incr/mode immediately on that edge.
REQ-022 cfg_wr to a running channel SHALL load pend_*, set pend_valid; a later write before application overwrites pend_*.
REQ-023 pend_* SHALL transfer to incr/mode on the edge whose add carries out (that add uses old incr); pend_valid cleared; no shortened period.
REQ-024 sync_mask[ch]=1 SHALL set acc to 0, force tick[ch]=0, and apply any pending config, overriding carry and ckena on that edge.
REQ-025 cfg_wr and carry on the same edge for the same channel: the new value SHALL become pending, applied at the following carry.
REQ-026 Channels SHALL be fully independent; simultaneous sync of several channels SHALL align their phases exactly.

Reset
REQ-027 reset=0 SHALL asynchronously clear acc, incr, mode, pend_*, tick and ckout to 0 in every channel.
REQ-028 Release SHALL be synchronised internally (two-flop deassertion) so all channels leave reset on the same edge.
REQ-029 After release, no output SHALL toggle until a nonzero incr is configured and ckena is high.

Structure
REQ-030 Package tickgen_pkg SHALL hold the mode enum (MODE_SQUARE, MODE_PULSE) and the channel-config struct {incr, mode}.
REQ-031 One sub-module nco_channel SHALL implement REQ-013..REQ-025 for one channel; top generates Channels instances plus write decode and reset synchroniser.

Verification (Width=8, Channels=4)
REQ-032 ch0 incr=64, square, ckena=1 from acc=0 -> tick every 4th cycle; ckout 2 cycles high, 2 low, period 4.
REQ-033 ch1 incr=3, pulse -> exactly 3 ticks per 256 cycles, spacing 85/85/86 in rotation; ckout==tick.
REQ-034 ch0 running incr=64, write incr=128 at acc=128 -> next tick at acc wrap (2 cycles later) with old incr, then ticks every 2 cycles.
REQ-035 sync_mask=0011 on the edge ch0 would carry -> no tick on ch0, acc0=acc1=0, subsequent ticks of ch0/ch1 coincident when incr equal.
REQ-036 reset low mid-run -> all ckout/tick 0 within same cycle without clock; after release and incr=32 write, first tick 8 cycles after ckena.
REQ-037 ckena[2] low 10 cycles with incr=16 -> acc frozen, no ticks, ckout held; resumes from held acc value.

Source files
------------

// File: rtl/tickgen_pkg.sv
// ---------------------------------------------------------------------------
// tickgen_pkg
// Shared types for the multi-channel NCO tick generator.
//   mode_e   : output style of a channel (square wave or one-cycle pulse)
//   ch_cfg_t : one channel configuration word {incr, mode}. The increment
//              field is sized for the widest supported accumulator; narrower
//              instances zero-extend into it, so the unused upper bits are
//              constant and disappear in synthesis.
// ---------------------------------------------------------------------------
package tickgen_pkg;

    localparam int INCR_MAX_W = 48;
    localparam int CH_IDX_W   = 4;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [INCR_MAX_W-1:0] incr;
        mode_e                 mode;
    } ch_cfg_t;

endpackage

// File: rtl/nco_channel.sv
// ---------------------------------------------------------------------------
// nco_channel
// One phase-accumulator channel. Each enabled cycle the accumulator advances
// by incr; the carry out of that add becomes a one-cycle tick. Configuration
// written while the channel is running is held pending and only takes effect
// on a wrap (or a sync), so no output period is ever shortened.
// Ports:
//   clock  : system clock
//   rst_n  : asynchronous active-low reset (already release-synchronised)
//   ckena  : run enable
//   sync   : phase clear, also applies any pending configuration
//   cfg_wr : configuration write strobe already decoded for this channel
//   cfg_in : configuration word {incr, mode}
//   ckout  : square (acc MSB) or pulse (== tick) output, registered
//   tick   : one-cycle wrap strobe, registered
// ---------------------------------------------------------------------------
module nco_channel
    import tickgen_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic    clock,
    input  logic    rst_n,
    input  logic    ckena,
    input  logic    sync,
    input  logic    cfg_wr,
    input  ch_cfg_t cfg_in,
    output logic    ckout,
    output logic    tick
);

    logic [Width-1:0] acc_q, acc_d;
    ch_cfg_t          cur_q, cur_d;
    ch_cfg_t          pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             ckout_q, ckout_d;

    logic [Width:0]   sum;
    logic             carry;
    logic             idle;

    always_comb begin
        // Upper increment bits are always zero, so truncating to Width+1
        // gives the exact modulo-2^Width sum plus carry.
        sum   = {1'b0, acc_q} + (Width + 1)'(cur_q.incr);
        carry = sum[Width];
        // A stopped or zero-increment channel has no period in progress, so
        // a write there can take effect at once.
        idle  = !ckena || (cur_q.incr == '0);

        acc_d        = acc_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;

        if (sync) begin
            acc_d = '0;
            if (pend_valid_q) begin
                cur_d        = pend_q;
                pend_valid_d = 1'b0;
            end
        end else if (ckena) begin
            acc_d  = sum[Width-1:0];
            tick_d = carry;
            // The wrapping add itself used the old increment; the new one
            // starts with the next period.
            if (carry && pend_valid_q) begin
                cur_d        = pend_q;
                pend_valid_d = 1'b0;
            end
        end

        // Evaluated after the carry transfer so a write landing on a wrap
        // edge stays pending for the following wrap.
        if (cfg_wr) begin
            if (idle) begin
                cur_d        = cfg_in;
                pend_valid_d = 1'b0;
            end else begin
                pend_d       = cfg_in;
                pend_valid_d = 1'b1;
            end
        end

        // Output is registered from next-state values so ckout is a plain
        // flop output in both modes.
        ckout_d = (cur_d.mode == MODE_PULSE) ? tick_d : acc_d[Width-1];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            ckout_q      <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            ckout_q      <= ckout_d;
        end
    end

    assign ckout = ckout_q;
    assign tick  = tick_q;

endmodule

// File: rtl/tickgen_nco.sv
// ---------------------------------------------------------------------------
// tickgen_nco
// Multi-channel numerically controlled tick/clock generator.
// Ports:
//   clock     : system clock
//   reset     : asynchronous active-low reset
//   ckena     : per-channel run enable
//   cfg_wr    : single-cycle configuration write strobe
//   cfg_ch    : target channel of the write (indices >= Channels ignored)
//   cfg_incr  : phase increment, f_out = f_clock * cfg_incr / 2^Width
//   cfg_mode  : 0 = square output, 1 = pulse output
//   sync_mask : per-channel phase clear, sampled every cycle
//   ckout     : per-channel clock output
//   tick      : per-channel one-cycle wrap strobe
// ---------------------------------------------------------------------------
module tickgen_nco
    import tickgen_pkg::*;
#(
    parameter int Channels = 4,
    parameter int Width    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [Channels-1:0] ckena,
    input  logic                cfg_wr,
    input  logic [3:0]          cfg_ch,
    input  logic [Width-1:0]    cfg_incr,
    input  logic                cfg_mode,
    input  logic [Channels-1:0] sync_mask,
    output logic [Channels-1:0] ckout,
    output logic [Channels-1:0] tick
);

    // Reset asserts immediately but releases through two flops so every
    // channel leaves reset on the same clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    ch_cfg_t wr_cfg;

    always_comb begin
        wr_cfg      = '0;
        wr_cfg.incr = INCR_MAX_W'(cfg_incr);
        wr_cfg.mode = mode_e'(cfg_mode);
    end

    // Exact index match: a write to a channel number that is not built
    // selects nothing.
    logic [Channels-1:0] ch_wr;

    for (genvar i = 0; i < Channels; i++) begin : g_ch
        assign ch_wr[i] = cfg_wr && (cfg_ch == CH_IDX_W'(i));

        nco_channel #(
            .Width (Width)
        ) u_ch (
            .clock  (clock),
            .rst_n  (rst_n_int),
            .ckena  (ckena[i]),
            .sync   (sync_mask[i]),
            .cfg_wr (ch_wr[i]),
            .cfg_in (wr_cfg),
            .ckout  (ckout[i]),
            .tick   (tick[i])
        );
    end

endmodule

// File: tb/tb_tickgen_nco.sv
// ---------------------------------------------------------------------------
// tb_tickgen_nco
// Directed scoreboard bench for tickgen_nco (Width=8, Channels=4).
// Stimulus pushes {cycle, channel, tick, ckout} expectations; a monitor
// sampling 1 time unit after each rising edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_tickgen_nco;
    import tickgen_pkg::*;

    localparam int CH = 4;
    localparam int W  = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [CH-1:0] ckena     = '0;
    logic          cfg_wr    = 1'b0;
    logic [3:0]    cfg_ch    = '0;
    logic [W-1:0]  cfg_incr  = '0;
    logic          cfg_mode  = 1'b0;
    logic [CH-1:0] sync_mask = '0;
    logic [CH-1:0] ckout;
    logic [CH-1:0] tick;

    tickgen_nco #(
        .Channels (CH),
        .Width    (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ckena     (ckena),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_incr  (cfg_incr),
        .cfg_mode  (cfg_mode),
        .sync_mask (sync_mask),
        .ckout     (ckout),
        .tick      (tick)
    );

    always #5 clock = ~clock;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        int   cyc;
        int   ch;
        logic tk;
        logic ck;
        int   ph;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(int c, int ch, logic tk, logic ck, int ph);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.tk  = tk;
        e.ck  = ck;
        e.ph  = ph;
        sb.push_back(e);
    endtask

    always @(posedge clock) begin
        exp_t keep[$];
        #1;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (tick[sb[i].ch] !== sb[i].tk || ckout[sb[i].ch] !== sb[i].ck) begin
                    errors++;
                    $display("FAIL ph%0d cyc%0d ch%0d: got tick=%b ckout=%b, want tick=%b ckout=%b",
                             sb[i].ph, cyc, sb[i].ch, tick[sb[i].ch], ckout[sb[i].ch],
                             sb[i].tk, sb[i].ck);
                end
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale ph%0d entry for cyc%0d seen at cyc%0d", sb[i].ph, sb[i].cyc, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic wr(int ch, int incr, logic md);
        cfg_wr   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_incr = W'(incr);
        cfg_mode = md;
        @(negedge clock);
        cfg_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        int   b;
        int   r;
        int   a;
        int   m;
        int   j;
        int   kk;
        logic t;
        logic frz;

        #1 reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        for (int k = 4; k <= 8; k++)
            for (int ch = 0; ch < CH; ch++) push_exp(k, ch, 1'b0, 1'b0, 0);

        // Configure while stopped: loads immediately.
        wait_cyc(6);
        wr(0, 64, 1'b0);
        wr(1, 3, 1'b1);
        wr(2, 16, 1'b0);

        // Square ch0 period 4, pulse ch1 3 ticks per 256 cycles.
        c = 10;
        wait_cyc(c);
        for (int k = 1; k <= 256; k++) begin
            a = (64 * k) % 256;
            push_exp(c + k, 0, (k % 4) == 0, a >= 128, 1);
            t = ((3 * k) / 256) != ((3 * (k - 1)) / 256);
            push_exp(c + k, 1, t, t, 1);
        end
        ckena = 4'b0011;

        // Increment change while running: takes effect at the next wrap.
        wait_cyc(c + 256);
        for (int k = 257; k <= 269; k++) begin
            if (k <= 260) begin
                a = (64 * k) % 256;
                push_exp(c + k, 0, (k % 4) == 0, a >= 128, 2);
            end else begin
                m = k - 260;
                push_exp(c + k, 0, (m % 2) == 0, (m % 2) == 1, 2);
            end
        end
        wait_cyc(c + 258);
        wr(0, 128, 1'b0);

        // Sync of ch0/ch1 on ch0's wrap edge, which also applies ch1's
        // pending increment; then a write landing on a wrap edge.
        wait_cyc(c + 268);
        for (int k = 270; k <= 284; k++) begin
            j = k - 270;
            push_exp(c + k, 1, (j > 0) && (j % 2 == 0), (j % 2) == 1, 3);
            if (k <= 277) begin
                push_exp(c + k, 0, (j > 0) && (j % 2 == 0), (j % 2) == 1, 3);
            end else begin
                m = k - 278;
                push_exp(c + k, 0, (m % 4) == 0, (m % 4) >= 2, 4);
            end
        end
        wr(1, 128, 1'b0);
        sync_mask = 4'b0011;
        wait_cyc(c + 270);
        sync_mask = 4'b0000;
        wait_cyc(c + 275);
        wr(0, 64, 1'b0);

        // ch2 enable gap with a write to a non-existent channel in between.
        b = c + 290;
        wait_cyc(b);
        for (int k = 1; k <= 34; k++) begin
            frz = (k >= 11) && (k <= 20);
            kk  = (k <= 10) ? k : (k <= 20) ? 10 : k - 10;
            push_exp(b + k, 2, !frz && ((kk % 16) == 0), (kk % 16) >= 8, 5);
        end
        ckena = 4'b0111;
        wait_cyc(b + 10);
        ckena = 4'b0011;
        wait_cyc(b + 14);
        wr(6, 255, 1'b1);
        wait_cyc(b + 20);
        ckena = 4'b0111;

        // Asynchronous reset mid-run, then restart from a clean state.
        wait_cyc(b + 34);
        for (int k = 35; k <= 44; k++)
            for (int ch = 0; ch < CH; ch++) push_exp(b + k, ch, 1'b0, 1'b0, 6);
        #2;
        reset = 1'b0;
        ckena = '0;
        #1;
        checks++;
        if (ckout !== '0) begin
            errors++;
            $display("FAIL async_reset_ckout: got %b want 0000", ckout);
        end
        checks++;
        if (tick !== '0) begin
            errors++;
            $display("FAIL async_reset_tick: got %b want 0000", tick);
        end
        wait_cyc(b + 37);
        reset = 1'b1;
        wait_cyc(b + 40);
        wr(0, 32, 1'b1);

        r = b + 44;
        wait_cyc(r);
        for (int k = 1; k <= 10; k++) begin
            push_exp(r + k, 0, k == 8, k == 8, 7);
            for (int ch = 1; ch < CH; ch++) push_exp(r + k, ch, 1'b0, 1'b0, 7);
        end
        ckena = 4'b1111;

        wait_cyc(r + 12);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
